// File: rtl/pat_seq_pkg.sv
// Shared types and helpers for the pattern-sequence and panel power controller.
package pat_seq_pkg;

   typedef enum logic [1:0] {
      OFF,
      RAMP_UP,
      ON,
      RAMP_DN
   } pwr_state_e;

   // Listed in descending request priority.
   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_NG,
      SRC_FIRST,
      SRC_LAST,
      SRC_UP,
      SRC_DN,
      SRC_RX
   } req_src_e;

   function automatic logic is_black(input logic [31:0] sn, input logic [31:0] patmax);
      return (sn == '0) || (sn == patmax);
   endfunction

endpackage

// File: rtl/pat_seq_ctrl_ms_timer.sv
// Millisecond prescaler feeding a loadable down-counter; o_done pulses in the
// last cycle of the loaded interval (immediately for a load of 0).
module ms_timer #(
   parameter int unsigned CLK_PER_MS = 81000,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_val,
   output logic             o_done
);
   localparam int unsigned      PRE_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);

   logic [PRE_W-1:0] r_pre;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             w_tick;

   assign w_tick = r_busy && (r_cnt != '0) && (r_pre == PRE_LAST);
   assign o_done = r_busy && ((r_cnt == '0) || (w_tick && (r_cnt == CNT_W'(1))));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_pre  <= '0;
      end else if (i_load) begin
         r_busy <= 1'b1;
         r_cnt  <= i_val;
         r_pre  <= '0;
      end else if (o_done) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_pre  <= '0;
      end else if (r_busy) begin
         if (w_tick) begin
            r_pre <= '0;
            r_cnt <= r_cnt - CNT_W'(1);
         end else begin
            r_pre <= r_pre + PRE_W'(1);
         end
      end
   end

endmodule

// File: rtl/pat_seq_ctrl.sv
// Pattern selection with per-pattern lock time and staged N-rail panel power
// sequencing; request arbitration, lock timer and power FSM.
module pat_seq_ctrl
   import pat_seq_pkg::*;
#(
   parameter int unsigned PAT_NUM    = 10,
   parameter int unsigned SN_W       = 7,
   parameter int unsigned RAIL_NUM   = 6,
   parameter int unsigned CLK_PER_MS = 81000,
   parameter int unsigned STEP_MS    = 500,
   parameter int unsigned LOCK_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      btn_up,
   input  logic                      btn_dn,
   input  logic                      btn_first,
   input  logic                      btn_last,
   input  logic                      ng,
   input  logic                      rx_valid,
   input  logic [SN_W-1:0]           rx_sn,
   input  logic [PAT_NUM*LOCK_W-1:0] lock_ms_tbl,
   output logic [SN_W-1:0]           dis_sn,
   output logic                      dis_chg,
   output logic                      locked,
   output logic [RAIL_NUM-1:0]       rail_en,
   output logic                      mux_en,
   output logic                      pwr_busy,
   output logic                      black_on
);
   localparam logic [SN_W-1:0] PATMAX    = SN_W'(PAT_NUM - 1);
   localparam logic [SN_W:0]   PAT_NUM_X = (SN_W + 1)'(PAT_NUM);
   localparam int unsigned     STEP_W    = (STEP_MS > 0) ? $clog2(STEP_MS + 1) : 1;

   req_src_e            w_src;
   logic [SN_W-1:0]     w_tgt;
   logic                w_chg;
   logic                w_rx_ok;
   logic [LOCK_W-1:0]   w_lock_val;
   logic                w_lock_done;
   logic                w_step_done;
   logic                w_step_load;
   pwr_state_e          r_state;
   pwr_state_e          w_state_nxt;
   logic [RAIL_NUM-1:0] w_rail_nxt;
   logic                w_mux_nxt;

   assign w_rx_ok = ({1'b0, rx_sn} < PAT_NUM_X);

   always_comb begin
      w_src = SRC_NONE;
      if (ng)                        w_src = SRC_NG;
      else if (!locked && !pwr_busy) begin
         if (btn_first)              w_src = SRC_FIRST;
         else if (btn_last)          w_src = SRC_LAST;
         else if (btn_up)            w_src = SRC_UP;
         else if (btn_dn)            w_src = SRC_DN;
         else if (rx_valid && w_rx_ok) w_src = SRC_RX;
      end
   end

   always_comb begin
      w_tgt = dis_sn;
      case (w_src)
         SRC_NG, SRC_LAST: w_tgt = PATMAX;
         SRC_FIRST:        w_tgt = '0;
         SRC_UP:           if (dis_sn != PATMAX) w_tgt = dis_sn + SN_W'(1);
         SRC_DN:           if (!is_black(32'(dis_sn), 32'(PATMAX))) w_tgt = dis_sn - SN_W'(1);
         SRC_RX:           w_tgt = rx_sn;
         default:          w_tgt = dis_sn;
      endcase
   end

   // A request resolving to the current pattern is treated as no request.
   assign w_chg = (w_tgt != dis_sn);

   always_comb begin
      w_lock_val = '0;
      for (int unsigned k = 0; k < PAT_NUM; k++)
         if (w_tgt == SN_W'(k)) w_lock_val = lock_ms_tbl[k*LOCK_W +: LOCK_W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dis_sn   <= '0;
         dis_chg  <= 1'b0;
         black_on <= 1'b1;
         locked   <= 1'b0;
      end else begin
         dis_sn   <= w_tgt;
         dis_chg  <= w_chg;
         black_on <= is_black(32'(dis_sn), 32'(PATMAX));
         if (w_chg)            locked <= 1'b1;
         else if (w_lock_done) locked <= 1'b0;
      end
   end

   ms_timer #(.CLK_PER_MS(CLK_PER_MS), .CNT_W(LOCK_W)) u_lock_tmr (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_chg),
      .i_val  (w_lock_val),
      .o_done (w_lock_done)
   );

   ms_timer #(.CLK_PER_MS(CLK_PER_MS), .CNT_W(STEP_W)) u_step_tmr (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_step_load),
      .i_val  (STEP_W'(STEP_MS)),
      .o_done (w_step_done)
   );

   // black_on still holds the previous pattern's class during the dis_chg cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_rail_nxt  = rail_en;
      w_mux_nxt   = mux_en;
      w_step_load = 1'b0;
      case (r_state)
         OFF: if (dis_chg && black_on && !is_black(32'(dis_sn), 32'(PATMAX))) begin
            w_state_nxt = RAMP_UP;
            w_rail_nxt  = RAIL_NUM'(1);
            w_step_load = 1'b1;
         end
         RAMP_UP: begin
            if (dis_chg && is_black(32'(dis_sn), 32'(PATMAX))) begin
               w_state_nxt = RAMP_DN;
               w_step_load = 1'b1;
            end else if (w_step_done) begin
               if (rail_en[RAIL_NUM-1]) begin
                  w_mux_nxt   = 1'b1;
                  w_state_nxt = ON;
               end else begin
                  w_rail_nxt  = (rail_en << 1) | RAIL_NUM'(1);
                  w_step_load = 1'b1;
               end
            end
         end
         ON: if (dis_chg && is_black(32'(dis_sn), 32'(PATMAX))) begin
            w_state_nxt = RAMP_DN;
            w_mux_nxt   = 1'b0;
            w_step_load = 1'b1;
         end
         RAMP_DN: if (w_step_done) begin
            w_rail_nxt = rail_en >> 1;
            if (w_rail_nxt == '0) w_state_nxt = OFF;
            else                  w_step_load = 1'b1;
         end
         default: w_state_nxt = OFF;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= OFF;
         rail_en  <= '0;
         mux_en   <= 1'b0;
         pwr_busy <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         rail_en  <= w_rail_nxt;
         mux_en   <= w_mux_nxt;
         pwr_busy <= (w_state_nxt == RAMP_UP) || (w_state_nxt == RAMP_DN);
      end
   end

endmodule

// File: tb/tb_pat_seq_ctrl.sv
// Scoreboard bench for pat_seq_ctrl: stimulus queues expected pattern changes
// and power-output transitions with their cycle; a negedge monitor pops them.
module tb_pat_seq_ctrl;
   localparam int unsigned S = 12;   // STEP_MS(3) * CLK_PER_MS(4)

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_up, btn_dn, btn_first, btn_last, ng, rx_valid;
   logic [6:0]  rx_sn;
   logic [159:0] lock_ms_tbl;
   logic [6:0]  dis_sn;
   logic        dis_chg, locked, mux_en, pwr_busy, black_on;
   logic [5:0]  rail_en;

   typedef struct {logic [6:0] sn; int cyc;} chg_t;
   typedef struct {logic [7:0] pw; int cyc;} pw_t;
   chg_t q_chg[$];
   pw_t  q_pw[$];

   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   logic [7:0] prev_pw = '0;

   pat_seq_ctrl #(.PAT_NUM(10), .SN_W(7), .RAIL_NUM(6), .CLK_PER_MS(4), .STEP_MS(3), .LOCK_W(16)) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_first(btn_first),
      .btn_last(btn_last), .ng(ng), .rx_valid(rx_valid), .rx_sn(rx_sn),
      .lock_ms_tbl(lock_ms_tbl), .dis_sn(dis_sn), .dis_chg(dis_chg), .locked(locked),
      .rail_en(rail_en), .mux_en(mux_en), .pwr_busy(pwr_busy), .black_on(black_on)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Power word is {rail_en, mux_en, pwr_busy}.
   task automatic exp_pw(input logic [5:0] rail, input logic mux, input logic busy, input int c);
      q_pw.push_back('{{rail, mux, busy}, c});
   endtask

   task automatic exp_ramp_up(input int c, input int n_rails, input bit full);
      for (int k = 0; k < n_rails; k++) exp_pw(6'((1 << (k + 1)) - 1), 1'b0, 1'b1, c + 1 + k * S);
      if (full) exp_pw(6'h3f, 1'b1, 1'b0, c + 1 + 6 * S);
   endtask

   task automatic exp_ramp_dn(input int c, input logic [5:0] start, input bit from_on);
      logic [5:0] r;
      int j;
      r = start;
      j = 0;
      if (from_on) exp_pw(start, 1'b0, 1'b1, c + 1);
      while (r != '0) begin
         r = r >> 1;
         j++;
         exp_pw(r, 1'b0, r != '0, c + 1 + j * S);
      end
   endtask

   task automatic wait_until(input int c);
      if (cyc > c) chk("schedule", cyc, c);
      while (cyc < c) @(negedge clk);
   endtask

   // bits: {ng, first, last, up, dn, rx_valid}
   task automatic pulse(input logic [5:0] b, input logic [6:0] sn);
      {ng, btn_first, btn_last, btn_up, btn_dn, rx_valid} = b;
      rx_sn = sn;
      @(negedge clk);
      {ng, btn_first, btn_last, btn_up, btn_dn, rx_valid} = '0;
      rx_sn = '0;
   endtask

   always @(negedge clk) begin
      logic [7:0] pw;
      chg_t e;
      pw_t  p;
      if (dis_chg) begin
         if (q_chg.size() == 0) chk("unexpected_dis_chg", 32'(dis_sn), 32'hffff);
         else begin
            e = q_chg.pop_front();
            chk("chg_sn", 32'(dis_sn), 32'(e.sn));
            chk("chg_cycle", cyc, e.cyc);
            chk("chg_locked", 32'(locked), 1);
         end
      end
      pw = {rail_en, mux_en, pwr_busy};
      if (pw != prev_pw) begin
         if (q_pw.size() == 0) chk("unexpected_pwr_change", 32'(pw), 32'hffff);
         else begin
            p = q_pw.pop_front();
            chk("pwr_value", 32'(pw), 32'(p.pw));
            chk("pwr_cycle", cyc, p.cyc);
         end
      end
      prev_pw = pw;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

   initial begin
      int lk[10] = '{0, 20, 1, 2, 5, 1, 1, 1, 1, 3};
      int b, c3, d;
      for (int k = 0; k < 10; k++) lock_ms_tbl[k*16 +: 16] = 16'(lk[k]);
      {ng, btn_first, btn_last, btn_up, btn_dn, rx_valid} = '0;
      rx_sn = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_dis_sn", 32'(dis_sn), 0);
      chk("rst_rail_en", 32'(rail_en), 0);
      chk("rst_mux_en", 32'(mux_en), 0);
      chk("rst_dis_chg", 32'(dis_chg), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_pwr_busy", 32'(pwr_busy), 0);
      chk("rst_black_on", 32'(black_on), 1);

      // Power-up from black, then lock blocks repeated btn_up
      b = cyc;
      q_chg.push_back('{7'd1, b + 1});
      exp_ramp_up(b + 1, 6, 1);
      pulse(6'b000100, '0);
      chk("black_on_still_old", 32'(black_on), 1);
      @(negedge clk);
      chk("black_on_T2", 32'(black_on), 0);
      for (int i = 1; i <= 8; i++) begin
         wait_until(b + 10 * i);
         if (i == 8) chk("lock_last_cycle", 32'(locked), 1);
         pulse(6'b000100, '0);
      end
      chk("lock_expired", 32'(locked), 0);
      chk("ramp_done_busy", 32'(pwr_busy), 0);
      chk("ramp_done_mux", 32'(mux_en), 1);
      wait_until(b + 90);
      q_chg.push_back('{7'd2, b + 91});
      pulse(6'b000100, '0);

      // up+dn together, out-of-range host request, valid host request
      wait_until(b + 100);
      q_chg.push_back('{7'd3, b + 101});
      pulse(6'b000100, '0);
      wait_until(b + 110);
      q_chg.push_back('{7'd4, b + 111});
      pulse(6'b000110, '0);
      wait_until(b + 135);
      pulse(6'b000001, 7'd12);
      @(negedge clk);
      chk("rx_out_of_range", 32'(dis_sn), 4);
      wait_until(b + 140);
      q_chg.push_back('{7'd5, b + 141});
      pulse(6'b000001, 7'd5);

      // btn_first from ON: full power-down; btn_up dropped while busy
      wait_until(b + 150);
      q_chg.push_back('{7'd0, b + 151});
      exp_ramp_dn(b + 151, 6'h3f, 1);
      pulse(6'b010000, '0);
      @(negedge clk);
      chk("black_on_after_first", 32'(black_on), 1);
      wait_until(b + 160);
      pulse(6'b000100, '0);

      // ng mid-ramp-up at rail_en=7, held for several cycles
      wait_until(b + 230);
      c3 = cyc + 1;
      q_chg.push_back('{7'd1, c3});
      exp_ramp_up(c3, 3, 0);
      pulse(6'b000100, '0);
      wait_until(c3 + 28);
      chk("rails_before_ng", 32'(rail_en), 7);
      q_chg.push_back('{7'd9, c3 + 29});
      exp_ramp_dn(c3 + 29, 6'h07, 0);
      ng = 1'b1;
      repeat (3) @(negedge clk);
      ng = 1'b0;
      wait_until(c3 + 40);
      chk("ng_mux_off", 32'(mux_en), 0);

      // btn_dn holds at PATMAX; btn_first with rails off; priority
      wait_until(c3 + 70);
      pulse(6'b000010, '0);
      @(negedge clk);
      chk("dn_at_max_holds", 32'(dis_sn), 9);
      wait_until(c3 + 75);
      q_chg.push_back('{7'd0, c3 + 76});
      pulse(6'b010000, '0);
      wait_until(c3 + 80);
      chk("first_no_ramp_busy", 32'(pwr_busy), 0);
      chk("first_black_on", 32'(black_on), 1);
      wait_until(c3 + 82);
      q_chg.push_back('{7'd9, c3 + 83});
      pulse(6'b001110, '0);
      wait_until(c3 + 96);
      q_chg.push_back('{7'd0, c3 + 97});
      pulse(6'b011000, '0);

      // reset in the middle of power-down
      wait_until(c3 + 100);
      d = cyc + 1;
      q_chg.push_back('{7'd1, d});
      exp_ramp_up(d, 6, 1);
      pulse(6'b000100, '0);
      wait_until(d + 85);
      q_chg.push_back('{7'd9, d + 86});
      exp_pw(6'h3f, 1'b0, 1'b1, d + 87);
      exp_pw(6'h1f, 1'b0, 1'b1, d + 99);
      pulse(6'b001000, '0);
      wait_until(d + 104);
      #2;
      exp_pw(6'h00, 1'b0, 1'b0, d + 105);
      rst = 1'b1;
      #1;
      chk("async_rst_rail_en", 32'(rail_en), 0);
      chk("async_rst_mux_en", 32'(mux_en), 0);
      chk("async_rst_dis_sn", 32'(dis_sn), 0);
      chk("async_rst_pwr_busy", 32'(pwr_busy), 0);
      chk("async_rst_black_on", 32'(black_on), 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_dis_sn", 32'(dis_sn), 0);
      chk("chg_queue_empty", 32'(q_chg.size()), 0);
      chk("pwr_queue_empty", 32'(q_pw.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
